// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: sign-magnitude fixed-point multiply-accumulate processing
// element for a systolic array. Two-stage pipeline (multiply, then commit into
// one of N_ACC accumulator banks), a shiftable bank chain for draining results
// to the neighbouring PE, and registered operand pass-through.
// Optional feature: define PE_SATURATE_EN to clamp overflowing magnitudes to
// the largest representable value; otherwise overflowing magnitudes wrap.
module systolic_mac_pe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int N_ACC  = 4,
  localparam int SEL_W = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wgt,
  input  logic              wgt_valid,
  input  logic [DATA_W-1:0] act,
  input  logic              act_valid,
  input  logic [SEL_W-1:0]  acc_sel,
  input  logic              clear_acc,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] acc_shift_in,
  output logic [DATA_W-1:0] acc_shift_out,
  output logic [DATA_W-1:0] wgt_out,
  output logic [DATA_W-1:0] act_out,
  output logic              wgt_valid_out,
  output logic              act_valid_out,
  output logic [SEL_W-1:0]  acc_sel_out,
  output logic              pending,
  output logic              sat_flag
);

  localparam int MAG_W  = DATA_W - 1;
  localparam int PROD_W = 2 * MAG_W;
  localparam logic [MAG_W-1:0] MAG_MAX = '1;

  logic [DATA_W-1:0] bank_q [N_ACC];
  logic [DATA_W-1:0] bank_d [N_ACC];
  logic              s1Valid_q, s1Valid_d;
  logic [MAG_W-1:0]  s1Mag_q, s1Mag_d;
  logic              s1Sign_q, s1Sign_d;
  logic [SEL_W-1:0]  s1Tag_q, s1Tag_d;
  logic              satFlag_q, satFlag_d;
  logic [DATA_W-1:0] wgtOut_q, wgtOut_d;
  logic [DATA_W-1:0] actOut_q, actOut_d;
  logic              wgtValidOut_q, wgtValidOut_d;
  logic              actValidOut_q, actValidOut_d;
  logic [SEL_W-1:0]  accSelOut_q, accSelOut_d;

  logic [PROD_W-1:0] prodFull;
  logic [PROD_W-1:0] prodShift;
  logic              prodOvf;
  logic [MAG_W-1:0]  prodMag;
  logic              prodSign;
  logic              accept;

  logic [DATA_W-1:0] bankCur;
  logic [MAG_W:0]    magSum;
  logic [MAG_W-1:0]  sumMag;
  logic              sumSign;
  logic              sumOvf;

  // Stage-1 product: truncated fixed-point magnitude, overflow folding, and
  // a sign that is forced positive whenever the magnitude is zero.
  always_comb begin
    prodFull  = PROD_W'(wgt[MAG_W-1:0]) * PROD_W'(act[MAG_W-1:0]);
    prodShift = prodFull >> FRAC_W;
    prodOvf   = |prodShift[PROD_W-1:MAG_W];
    prodMag   = prodShift[MAG_W-1:0];
`ifdef PE_SATURATE_EN
    if (prodOvf) prodMag = MAG_MAX;
`endif
    prodSign  = (wgt[DATA_W-1] ^ act[DATA_W-1]) & (prodMag != '0);
    accept    = wgt_valid & act_valid & ~shift_en & ~clear_acc;
  end

  // Stage-2 sign-magnitude add of the pending product onto its target bank.
  always_comb begin
    bankCur = bank_q[s1Tag_q];
    sumOvf  = 1'b0;
    sumSign = bankCur[DATA_W-1];
    if (bankCur[DATA_W-1] == s1Sign_q) begin
      magSum = {1'b0, bankCur[MAG_W-1:0]} + {1'b0, s1Mag_q};
      sumOvf = magSum[MAG_W];
    end else if (bankCur[MAG_W-1:0] >= s1Mag_q) begin
      magSum = {1'b0, bankCur[MAG_W-1:0] - s1Mag_q};
    end else begin
      magSum  = {1'b0, s1Mag_q - bankCur[MAG_W-1:0]};
      sumSign = s1Sign_q;
    end
    sumMag = magSum[MAG_W-1:0];
`ifdef PE_SATURATE_EN
    if (sumOvf) sumMag = MAG_MAX;
`endif
    if (sumMag == '0) sumSign = 1'b0;
  end

  // Next-state selection: clear beats shift, shift beats normal MAC flow.
  always_comb begin
    for (int i = 0; i < N_ACC; i++) bank_d[i] = bank_q[i];
    s1Valid_d     = s1Valid_q;
    s1Mag_d       = s1Mag_q;
    s1Sign_d      = s1Sign_q;
    s1Tag_d       = s1Tag_q;
    satFlag_d     = satFlag_q;
    wgtOut_d      = wgtOut_q;
    actOut_d      = actOut_q;
    wgtValidOut_d = 1'b0;
    actValidOut_d = 1'b0;
    accSelOut_d   = accSelOut_q;
    if (clear_acc) begin
      for (int i = 0; i < N_ACC; i++) bank_d[i] = '0;
      s1Valid_d = 1'b0;
      satFlag_d = 1'b0;
    end else if (shift_en) begin
      bank_d[0] = acc_shift_in;
      for (int i = 1; i < N_ACC; i++) bank_d[i] = bank_q[i-1];
    end else begin
      wgtOut_d      = wgt;
      actOut_d      = act;
      wgtValidOut_d = wgt_valid;
      actValidOut_d = act_valid;
      accSelOut_d   = acc_sel;
      if (s1Valid_q && (int'(s1Tag_q) < N_ACC)) begin
        bank_d[s1Tag_q] = {sumSign, sumMag};
        if (sumOvf) satFlag_d = 1'b1;
      end
      s1Valid_d = accept;
      if (accept) begin
        s1Mag_d  = prodMag;
        s1Sign_d = prodSign;
        s1Tag_d  = (N_ACC == 1) ? '0 : acc_sel;
        if (prodOvf) satFlag_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset that discards any in-flight product.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ACC; i++) bank_q[i] <= '0;
      s1Valid_q     <= 1'b0;
      s1Mag_q       <= '0;
      s1Sign_q      <= 1'b0;
      s1Tag_q       <= '0;
      satFlag_q     <= 1'b0;
      wgtOut_q      <= '0;
      actOut_q      <= '0;
      wgtValidOut_q <= 1'b0;
      actValidOut_q <= 1'b0;
      accSelOut_q   <= '0;
    end else begin
      for (int i = 0; i < N_ACC; i++) bank_q[i] <= bank_d[i];
      s1Valid_q     <= s1Valid_d;
      s1Mag_q       <= s1Mag_d;
      s1Sign_q      <= s1Sign_d;
      s1Tag_q       <= s1Tag_d;
      satFlag_q     <= satFlag_d;
      wgtOut_q      <= wgtOut_d;
      actOut_q      <= actOut_d;
      wgtValidOut_q <= wgtValidOut_d;
      actValidOut_q <= actValidOut_d;
      accSelOut_q   <= accSelOut_d;
    end
  end

  assign acc_shift_out = bank_q[N_ACC-1];
  assign wgt_out       = wgtOut_q;
  assign act_out       = actOut_q;
  assign wgt_valid_out = wgtValidOut_q;
  assign act_valid_out = actValidOut_q;
  assign acc_sel_out   = accSelOut_q;
  assign pending       = s1Valid_q;
  assign sat_flag      = satFlag_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// tb_systolic_mac_pe: directed, table-driven checks of systolic_mac_pe with
// DATA_W=16, FRAC_W=8, N_ACC=4. Expected values are hand-computed constants.
module tb_systolic_mac_pe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wgt, act, accShiftIn;
  logic        wgtValid, actValid, clearAcc, shiftEn;
  logic [1:0]  accSel;
  logic [15:0] accShiftOut, wgtOut, actOut;
  logic        wgtValidOut, actValidOut, pending, satFlag;
  logic [1:0]  accSelOut;

  int checks   = 0;
  int failures = 0;
  logic [15:0] seen [4];

  typedef struct {
    logic [15:0] w;
    logic [15:0] a;
    logic [15:0] expBank;
    logic        expSat;
  } vec_t;

  vec_t vecs [11];

  systolic_mac_pe #(.DATA_W(16), .FRAC_W(8), .N_ACC(4)) dut (
    .clk(clk), .rst(rst), .wgt(wgt), .wgt_valid(wgtValid), .act(act),
    .act_valid(actValid), .acc_sel(accSel), .clear_acc(clearAcc),
    .shift_en(shiftEn), .acc_shift_in(accShiftIn), .acc_shift_out(accShiftOut),
    .wgt_out(wgtOut), .act_out(actOut), .wgt_valid_out(wgtValidOut),
    .act_valid_out(actValidOut), .acc_sel_out(accSelOut), .pending(pending),
    .sat_flag(satFlag)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    wgtValid = 1'b0; actValid = 1'b0; clearAcc = 1'b0; shiftEn = 1'b0;
    wgt = 16'h0; act = 16'h0; accSel = 2'd0; accShiftIn = 16'h0;
  endtask

  // Drive one operand pair for a single cycle, then return inputs to idle.
  task automatic applyStimulus(input logic [15:0] w, input logic [15:0] a,
                               input logic [1:0] sel);
    wgt = w; act = a; accSel = sel; wgtValid = 1'b1; actValid = 1'b1;
    tick();
    idleInputs();
  endtask

  // Rotate the bank chain once around, recording every bank and restoring it.
  task automatic readBanks();
    for (int k = 0; k < 4; k++) begin
      seen[3-k]  = accShiftOut;
      accShiftIn = accShiftOut;
      shiftEn    = 1'b1;
      tick();
    end
    shiftEn = 1'b0; accShiftIn = 16'h0;
  endtask

  initial begin
    vecs[0]  = '{16'h0100, 16'h0300, 16'h0300, 1'b0};
    vecs[1]  = '{16'h8200, 16'h0100, 16'h0100, 1'b0};
    vecs[2]  = '{16'h8100, 16'h8200, 16'h0300, 1'b0};
    vecs[3]  = '{16'h0080, 16'h8800, 16'h8100, 1'b0};
    vecs[4]  = '{16'h0001, 16'h0001, 16'h8100, 1'b0};
    vecs[5]  = '{16'h8001, 16'h0001, 16'h8100, 1'b0};
    vecs[6]  = '{16'h0100, 16'h0100, 16'h0000, 1'b0};
    vecs[7]  = '{16'h8000, 16'h0100, 16'h0000, 1'b0};
    vecs[8]  = '{16'h80FF, 16'h0101, 16'h80FF, 1'b0};
    vecs[9]  = '{16'h0200, 16'h0080, 16'h0001, 1'b0};
`ifdef PE_SATURATE_EN
    vecs[10] = '{16'h7FFF, 16'h0100, 16'h7FFF, 1'b1};
`else
    vecs[10] = '{16'h7FFF, 16'h0100, 16'h0000, 1'b1};
`endif

    // Reset with busy inputs: everything must come up zero.
    idleInputs();
    rst = 1'b1; wgt = 16'h1234; act = 16'h5678; wgtValid = 1'b1; actValid = 1'b1;
    accSel = 2'd3;
    tick(); tick();
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_sat", satFlag, 0);
    checkOutput("rst_wgt_out", wgtOut, 0);
    checkOutput("rst_act_out", actOut, 0);
    checkOutput("rst_valid_outs", {wgtValidOut, actValidOut}, 0);
    checkOutput("rst_sel_out", accSelOut, 0);
    checkOutput("rst_shift_out", accShiftOut, 0);
    rst = 1'b0; idleInputs();
    tick();

    // Single MAC into bank 0 with pass-through and pending pulse.
    applyStimulus(16'h0180, 16'h0200, 2'd0);
    checkOutput("mac0_pending", pending, 1);
    checkOutput("mac0_wgt_out", wgtOut, 16'h0180);
    checkOutput("mac0_act_out", actOut, 16'h0200);
    checkOutput("mac0_valid_outs", {wgtValidOut, actValidOut}, 2'b11);
    tick();
    checkOutput("mac0_pending_drop", pending, 0);
    checkOutput("mac0_valid_drop", {wgtValidOut, actValidOut}, 0);
    readBanks();
    checkOutput("mac0_bank0", seen[0], 16'h0300);
    checkOutput("mac0_bank1", seen[1], 16'h0000);

    // Back-to-back accumulation into bank 1, then back to +0.
    wgt = 16'h0100; act = 16'h0200; accSel = 2'd1; wgtValid = 1'b1; actValid = 1'b1;
    tick();
    checkOutput("b2b_sel_out", accSelOut, 2'd1);
    wgt = 16'h8100; act = 16'h0300;
    tick();
    idleInputs();
    tick();
    readBanks();
    checkOutput("b2b_bank1_neg", seen[1], 16'h8100);
    checkOutput("b2b_bank0_kept", seen[0], 16'h0300);
    applyStimulus(16'h0100, 16'h0100, 2'd1);
    tick();
    readBanks();
    checkOutput("b2b_bank1_pos0", seen[1], 16'h0000);

    // Only one operand valid: copied through, no product accepted.
    wgt = 16'h0A00; act = 16'h0B00; wgtValid = 1'b1; actValid = 1'b0; accSel = 2'd3;
    tick();
    idleInputs();
    checkOutput("half_valid_outs", {wgtValidOut, actValidOut}, 2'b10);
    checkOutput("half_pending", pending, 0);

    // Product overflow into bank 2.
    applyStimulus(16'h7F00, 16'h0200, 2'd2);
    tick();
    checkOutput("ovf_sat", satFlag, 1);
    readBanks();
`ifdef PE_SATURATE_EN
    checkOutput("ovf_bank2", seen[2], 16'h7FFF);
`else
    checkOutput("ovf_bank2", seen[2], 16'h7E00);
`endif

    // Clear wipes banks and sat_flag.
    clearAcc = 1'b1;
    tick();
    clearAcc = 1'b0;
    checkOutput("clr_sat", satFlag, 0);
    readBanks();
    checkOutput("clr_bank0", seen[0], 16'h0000);
    checkOutput("clr_bank2", seen[2], 16'h0000);

    // Table of accumulations into bank 3 (directly visible on acc_shift_out).
    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].w, vecs[v].a, 2'd3);
      tick();
      checkOutput($sformatf("vec%0d_bank3", v), accShiftOut, vecs[v].expBank);
      checkOutput($sformatf("vec%0d_sat", v), satFlag, vecs[v].expSat);
    end

    // Load banks 1..4 and shift them out past acc_shift_out.
    clearAcc = 1'b1; tick(); clearAcc = 1'b0;
    wgtValid = 1'b1; actValid = 1'b1; act = 16'h0100;
    for (int b = 0; b < 4; b++) begin
      wgt = 16'((b + 1) * 256); accSel = 2'(b);
      tick();
    end
    idleInputs();
    tick();
    accShiftIn = 16'h0500; shiftEn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("shift%0d_out", k), accShiftOut, 16'((4 - k) * 256));
      tick();
    end
    checkOutput("shift_valid_outs", {wgtValidOut, actValidOut}, 0);
    shiftEn = 1'b0; accShiftIn = 16'h0;
    readBanks();
    checkOutput("shift_bank0", seen[0], 16'h0500);

    // Pending product frozen across a 2-cycle shift, commits afterwards.
    clearAcc = 1'b1; tick(); clearAcc = 1'b0;
    applyStimulus(16'h0200, 16'h0100, 2'd1);
    shiftEn = 1'b1; accShiftIn = 16'h0100;
    wgt = 16'h0400; act = 16'h0100; wgtValid = 1'b1; actValid = 1'b1; accSel = 2'd3;
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput($sformatf("frz%0d_pending", k), pending, 1);
      checkOutput($sformatf("frz%0d_valid_outs", k), {wgtValidOut, actValidOut}, 0);
    end
    idleInputs();
    tick();
    checkOutput("frz_commit_pending", pending, 0);
    readBanks();
    checkOutput("frz_bank0", seen[0], 16'h0100);
    checkOutput("frz_bank1", seen[1], 16'h0300);
    checkOutput("frz_bank3", seen[3], 16'h0000);

    // clear_acc and then rst (during shift) with pending and sat_flag both set.
    for (int pass = 0; pass < 2; pass++) begin
      clearAcc = 1'b1; tick(); clearAcc = 1'b0;
      applyStimulus(16'h0100, 16'h0100, 2'd3);
      applyStimulus(16'h7F00, 16'h0200, 2'd2);
      tick();
      wgt = 16'h0200; act = 16'h0100; accSel = 2'd3; wgtValid = 1'b1; actValid = 1'b1;
      tick();
      idleInputs();
      checkOutput($sformatf("kill%0d_pre_pending", pass), pending, 1);
      checkOutput($sformatf("kill%0d_pre_sat", pass), satFlag, 1);
      checkOutput($sformatf("kill%0d_pre_bank3", pass), accShiftOut, 16'h0100);
      if (pass == 0) clearAcc = 1'b1;
      else begin
        rst = 1'b1; shiftEn = 1'b1; accShiftIn = 16'h0700;
      end
      tick();
      rst = 1'b0; idleInputs();
      checkOutput($sformatf("kill%0d_pending", pass), pending, 0);
      checkOutput($sformatf("kill%0d_sat", pass), satFlag, 0);
      checkOutput($sformatf("kill%0d_bank3", pass), accShiftOut, 16'h0000);
      tick();
      checkOutput($sformatf("kill%0d_no_commit", pass), accShiftOut, 16'h0000);
      readBanks();
      checkOutput($sformatf("kill%0d_bank2", pass), seen[2], 16'h0000);
    end

    // First accept after reset behaves normally.
    applyStimulus(16'h0180, 16'h0200, 2'd3);
    checkOutput("post_rst_pending", pending, 1);
    tick();
    checkOutput("post_rst_bank3", accShiftOut, 16'h0300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
